// File: rtl/dbus_pkg.sv
// Shared types and funct3 encodings for the MEM-stage data-bus bridge.
package dbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } dbus_state_e;

  localparam logic [2:0] MEM_OP_B  = 3'b000;
  localparam logic [2:0] MEM_OP_H  = 3'b001;
  localparam logic [2:0] MEM_OP_W  = 3'b010;
  localparam logic [2:0] MEM_OP_BU = 3'b100;
  localparam logic [2:0] MEM_OP_HU = 3'b101;

  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic [1:0] a;
    logic [2:0] op;
  } dbus_req_t;

endpackage

// File: rtl/dbus_lane_align.sv
// Byte-lane steering: store sel/data replication, fault detection and load extraction.
module dbus_lane_align
  import dbus_pkg::*;
(
  input  logic [1:0]  a,
  input  logic [2:0]  op,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdat,
  output logic [31:0] rdata_ext,
  output logic        fault
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = 8'(rdata >> {a, 3'b000});
  assign half_v = 16'(rdata >> {a[1], 4'b0000});

  // Store data per lane: byte ops replicate byte 0, half ops replicate the low halfword.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wdat[8*i +: 8] = (op[1:0] == 2'b00) ? wdata[7:0] :
                            (op[1:0] == 2'b01) ? wdata[8*(i%2) +: 8] :
                                                 wdata[8*i +: 8];
  end

  always_comb begin
    sel       = 4'h0;
    rdata_ext = '0;
    fault     = 1'b0;
    case (op)
      MEM_OP_B, MEM_OP_BU: begin
        sel       = 4'b0001 << a;
        rdata_ext = op[2] ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      MEM_OP_H, MEM_OP_HU: begin
        sel       = 4'b0011 << {a[1], 1'b0};
        fault     = a[0];
        rdata_ext = op[2] ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      end
      MEM_OP_W: begin
        sel       = 4'hF;
        fault     = |a;
        rdata_ext = rdata;
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/dbus_wb_bridge.sv
// Core MEM-stage load/store to single Wishbone classic cycle; stalls the core while busy.
// Optional BUS-state watchdog enabled by defining DBUS_TIMEOUT_EN.
module dbus_wb_bridge
  import dbus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr_mem,
  input  logic [31:0] mem_wdata_mem,
  input  logic        mem_write_mem,
  input  logic        mem_read_mem,
  input  logic [2:0]  mem_op_mem,
  output logic [31:0] mem_rdata_mem,
  output logic        stall_pipl,
  output logic        bus_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_chk
    $error("TIMEOUT_CYCLES out of range");
  end

  dbus_state_e state;
  dbus_req_t   req_q;
  logic        req;
  logic [1:0]  al_a;
  logic [2:0]  al_op;
  logic [3:0]  al_sel;
  logic [31:0] al_wdat;
  logic [31:0] al_rdata;
  logic        al_fault;

  assign req        = mem_read_mem | mem_write_mem;
  assign stall_pipl = ((state == IDLE) && req) || (state == BUS);

  // Aligner sees the live request while idle, the captured one during the cycle.
  assign al_a  = (state == IDLE) ? mem_addr_mem[1:0] : req_q.a;
  assign al_op = (state == IDLE) ? mem_op_mem        : req_q.op;

  dbus_lane_align u_align (
    .a         (al_a),
    .op        (al_op),
    .wdata     (mem_wdata_mem),
    .rdata     (wb_dat_i),
    .sel       (al_sel),
    .wdat      (al_wdat),
    .rdata_ext (al_rdata),
    .fault     (al_fault)
  );

`ifdef DBUS_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      req_q         <= '0;
      mem_rdata_mem <= '0;
      bus_err       <= 1'b0;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_we_o       <= 1'b0;
      wb_adr_o      <= '0;
      wb_dat_o      <= '0;
      wb_sel_o      <= '0;
`ifdef DBUS_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: if (req) begin
          req_q.a  <= mem_addr_mem[1:0];
          req_q.op <= mem_op_mem;
          if (al_fault) begin
            state         <= DONE;
            bus_err       <= 1'b1;
            mem_rdata_mem <= '0;
          end else begin
            state    <= BUS;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= mem_write_mem;
            wb_adr_o <= {mem_addr_mem[31:2], 2'b00};
            wb_sel_o <= al_sel;
            wb_dat_o <= al_wdat;
`ifdef DBUS_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end
        end
        BUS: begin
          if (wb_err_i) begin
            state         <= DONE;
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            bus_err       <= 1'b1;
            mem_rdata_mem <= '0;
          end else if (wb_ack_i) begin
            state    <= DONE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (!wb_we_o) mem_rdata_mem <= al_rdata;
          end
`ifdef DBUS_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            state         <= DONE;
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            bus_err       <= 1'b1;
            mem_rdata_mem <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_wb_bridge.sv
// Randomized bench for dbus_wb_bridge with a transaction-level reference model.
module tb_dbus_wb_bridge;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr_mem, mem_wdata_mem, mem_rdata_mem;
  logic        mem_write_mem, mem_read_mem;
  logic [2:0]  mem_op_mem;
  logic        stall_pipl, bus_err;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  dbus_wb_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .mem_addr_mem(mem_addr_mem), .mem_wdata_mem(mem_wdata_mem),
    .mem_write_mem(mem_write_mem), .mem_read_mem(mem_read_mem),
    .mem_op_mem(mem_op_mem), .mem_rdata_mem(mem_rdata_mem),
    .stall_pipl(stall_pipl), .bus_err(bus_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  function automatic logic is_fault(input logic [2:0] op, input logic [31:0] addr);
    int o = int'(op);
    int lo = int'(addr % 4);
    if (o == 3 || o >= 6) return 1'b1;
    if ((o == 1 || o == 5) && (lo % 2) != 0) return 1'b1;
    if (o == 2 && lo != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_sel(input logic [2:0] op, input logic [31:0] addr);
    int lo = int'(addr % 4);
    case (int'(op) % 4)
      0:       return 4'(1 << lo);
      1:       return (lo >= 2) ? 4'b1100 : 4'b0011;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_dat(input logic [2:0] op, input logic [31:0] wd);
    case (int'(op) % 4)
      0:       return (wd % 256) * 32'h01010101;
      1:       return (wd % 65536) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] d);
    logic [31:0] b, h;
    b = (d / (32'd1 << (8 * (addr % 4)))) % 256;
    h = (d / (32'd1 << (16 * ((addr % 4) / 2)))) % 65536;
    case (int'(op))
      0:       return (b >= 128) ? b - 32'd256 : b;
      1:       return (h >= 32768) ? h - 32'd65536 : h;
      4:       return b;
      5:       return h;
      default: return d;
    endcase
  endfunction

  // kind: 0 = ack after waits, 1 = err after waits, 2 = never respond
  task automatic access(input logic we, input logic both, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int waits, input int kind,
                        input string name);
    int stalls = 0;
    int bus_cycles = 0;
    int exp_bus, exp_stalls;
    logic fault, err_exp;
    fault = is_fault(op, addr);
    err_exp = fault || (kind != 0);
    exp_bus = fault ? 0 : ((kind == 2) ? TMO : waits + 1);
    exp_stalls = exp_bus + 1;
    @(negedge clk);
    mem_addr_mem = addr; mem_wdata_mem = wd; mem_op_mem = op;
    mem_write_mem = we; mem_read_mem = !we || both;
    wb_dat_i = rd; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    #1;
    if (stall_pipl) stalls++;
    @(posedge clk); @(negedge clk);
    while (wb_cyc_o === 1'b1 && bus_cycles < 300) begin
      if (stall_pipl) stalls++;
      if (bus_cycles == 0) begin
        checks++;
        if (wb_stb_o !== 1'b1 || wb_we_o !== we || wb_adr_o !== (addr & 32'hFFFF_FFFC) ||
            wb_sel_o !== exp_sel(op, addr) || (we && wb_dat_o !== exp_dat(op, wd))) begin
          failures++;
          $display("FAIL %s bus_ctl: stb=%b we=%b adr=%h sel=%b dat=%h, want stb=1 we=%b adr=%h sel=%b dat=%h",
                   name, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, we,
                   addr & 32'hFFFF_FFFC, exp_sel(op, addr), exp_dat(op, wd));
        end
      end
      wb_ack_i = (kind == 0 && bus_cycles == waits);
      wb_err_i = (kind == 1 && bus_cycles == waits);
      bus_cycles++;
      @(posedge clk); @(negedge clk);
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    if (err_exp) model_rdata = 32'h0;
    else if (!we) model_rdata = exp_load(op, addr, rd);
    checks++;
    if (bus_cycles != exp_bus || stalls != exp_stalls) begin
      failures++;
      $display("FAIL %s timing: bus_cycles=%0d stalls=%0d, want %0d %0d",
               name, bus_cycles, stalls, exp_bus, exp_stalls);
    end
    checks++;
    if (stall_pipl !== 1'b0 || wb_cyc_o !== 1'b0 || bus_err !== err_exp ||
        mem_rdata_mem !== model_rdata) begin
      failures++;
      $display("FAIL %s done: stall=%b cyc=%b bus_err=%b rdata=%h, want 0 0 %b %h",
               name, stall_pipl, wb_cyc_o, bus_err, mem_rdata_mem, err_exp, model_rdata);
    end
    mem_write_mem = 1'b0; mem_read_mem = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus_err !== 1'b0 || stall_pipl !== 1'b0 || mem_rdata_mem !== model_rdata) begin
      failures++;
      $display("FAIL %s after: bus_err=%b stall=%b rdata=%h, want 0 0 %h",
               name, bus_err, stall_pipl, mem_rdata_mem, model_rdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_addr_mem = '0; mem_wdata_mem = '0; mem_op_mem = '0;
    mem_write_mem = 1'b0; mem_read_mem = 1'b0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    model_rdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_rdata_mem, stall_pipl, bus_err, wb_cyc_o, wb_stb_o, wb_we_o,
         wb_adr_o, wb_dat_o, wb_sel_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rdata=%h stall=%b err=%b cyc=%b adr=%h dat=%h sel=%b, want all 0",
               mem_rdata_mem, stall_pipl, bus_err, wb_cyc_o, wb_adr_o, wb_dat_o, wb_sel_o);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    access(1'b0, 1'b0, 3'b010, 32'h1000, 32'h0, 32'hDEADBEEF, 1, 0, "lw_wait1");
    access(1'b0, 1'b0, 3'b000, 32'h1003, 32'h0, 32'h80112233, 0, 0, "lb_sign");
    access(1'b0, 1'b0, 3'b100, 32'h1003, 32'h0, 32'h80112233, 0, 0, "lbu");
    access(1'b1, 1'b0, 3'b001, 32'h2002, 32'h0000ABCD, 32'h5555AAAA, 0, 0, "sh_hi");
    access(1'b0, 1'b0, 3'b010, 32'h1002, 32'h0, 32'h12345678, 0, 0, "lw_misalign");
    access(1'b0, 1'b0, 3'b011, 32'h1000, 32'h0, 32'h12345678, 0, 0, "illegal_op");
    access(1'b0, 1'b0, 3'b101, 32'h1002, 32'h0, 32'h8001F00D, 2, 0, "lhu_hi");
    access(1'b1, 1'b0, 3'b010, 32'h3000, 32'hCAFEF00D, 32'h0, 1, 1, "sw_wb_err");
    access(1'b1, 1'b1, 3'b000, 32'h3001, 32'h000000A5, 32'hFFFFFFFF, 0, 0, "rw_both_store");
  endtask

  task automatic test_ack_outside_bus();
    access(1'b0, 1'b0, 3'b010, 32'h4000, 32'h0, 32'h01020304, 0, 0, "pre_outside");
    @(negedge clk);
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'hFFFFFFFF;
    @(posedge clk); @(negedge clk);
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (wb_cyc_o !== 1'b0 || bus_err !== 1'b0 || mem_rdata_mem !== model_rdata) begin
      failures++;
      $display("FAIL ack_outside_bus: cyc=%b bus_err=%b rdata=%h, want 0 0 %h",
               wb_cyc_o, bus_err, mem_rdata_mem, model_rdata);
    end
  endtask

  task automatic test_reset_mid_bus();
    @(negedge clk);
    mem_addr_mem = 32'h5000; mem_op_mem = 3'b010; mem_read_mem = 1'b1; mem_write_mem = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    mem_read_mem = 1'b0;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || stall_pipl !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_bus: cyc=%b stb=%b stall=%b, want 0 0 0", wb_cyc_o, wb_stb_o, stall_pipl);
    end
    model_rdata = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus_err !== 1'b0 || wb_cyc_o !== 1'b0 || mem_rdata_mem !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_bus_after: bus_err=%b cyc=%b rdata=%h, want 0 0 0",
               bus_err, wb_cyc_o, mem_rdata_mem);
    end
    access(1'b0, 1'b0, 3'b001, 32'h5002, 32'h0, 32'h7FFF0000, 0, 0, "post_reset_lh");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [31:0] addr;
      int kind;
      op = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (op == 3'b010) addr[1:0] = 2'b00;
        else if (op[1:0] == 2'b01) addr[0] = 1'b0;
      end
      kind = ($urandom_range(0, 5) == 0) ? 1 : 0;
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, addr, $urandom,
             $urandom, $urandom_range(0, 3), kind, "random");
    end
  endtask

`ifdef DBUS_TIMEOUT_EN
  task automatic test_timeout();
    access(1'b0, 1'b0, 3'b010, 32'h6000, 32'h0, 32'h11111111, 0, 2, "timeout_abort");
    access(1'b0, 1'b0, 3'b010, 32'h6004, 32'h0, 32'h22222222, TMO - 1, 0, "ack_on_expiry");
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_ack_outside_bus();
    test_reset_mid_bus();
    test_random();
`ifdef DBUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbus_wb_bridge.md
# dbus_wb_bridge

Data-memory responder for the RV32I core's MEM-stage bus: accepts the core's load/store request, converts it to a single Wishbone classic master cycle with byte-lane alignment, returns sign/zero-extended load data, and drives the core's `stall_pipl` input while the transaction is outstanding. Sits between the core top and the SoC Wishbone interconnect, one instance per core.

## Interface
- `TIMEOUT_CYCLES`, 255: max BUS-state cycles before abort (only with `DBUS_TIMEOUT_EN`); must be ≥1, ≤ 65535.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_addr_mem`  in  32  byte address from core.
- `mem_wdata_mem`  in  32  store data, LSB-aligned.
- `mem_write_mem`  in  1  store request.
- `mem_read_mem`  in  1  load request.
- `mem_op_mem`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `mem_rdata_mem`  out  32  extended load data to core.
- `stall_pipl`  out  1  core pipeline stall.
- `bus_err`  out  1  one-cycle pulse on failed access.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1  Wishbone master controls.
- `wb_adr_o`  out  32  word address, bits [1:0] = 0.
- `wb_dat_o`  out  32  lane-replicated store data.
- `wb_sel_o`  out  4  byte enables.
- `wb_dat_i`  in  32  read data.
- `wb_ack_i`, `wb_err_i`  in  1  slave termination.

## Operation
- FSM states IDLE, BUS, DONE. Request `req = mem_read_mem | mem_write_mem`; write has priority if both set.
- IDLE: on `req`, register address/op/wdata/we, compute lanes. Legal & aligned → BUS. Misaligned (H with addr[0]=1, W with addr[1:0]≠0) or illegal funct3 (011,110,111) → DONE with error flag, no bus cycle.
- BUS: `wb_cyc_o=wb_stb_o=1`, registered adr/dat/sel/we held stable. `wb_ack_i` → capture extended read data (loads only), → DONE. `wb_err_i` (wins over ack) → `mem_rdata_mem`=0, error flag, → DONE.
- DONE: cyc/stb low, `stall_pipl`=0, `bus_err`=error flag; unconditionally → IDLE next cycle.
- `stall_pipl = (IDLE & req) | BUS` (combinational); core holds request stable while stalled.
- Lanes: B sel = 1<<a[1:0], dat = {4{wdata[7:0]}}; H sel = 4'b0011<<{a[1],0}, dat = {2{wdata[15:0]}}; W sel = 4'hF, dat = wdata.
- Load extract: byte/halfword selected by a[1:0]/a[1]; B, H sign-extend; BU, HU zero-extend; W pass-through.
- `mem_rdata_mem` registered, holds last value until next completed load; stores leave it unchanged.

## Timing
- Reset: state IDLE; all outputs 0 (`stall_pipl` follows combinational rule, i.e. 0 with no request).
- Min access: 3 cycles (IDLE detect, BUS with ack same cycle, DONE); `stall_pipl` high 2 cycles. Each extra wait state adds one.
- Load data valid in DONE cycle, the cycle core unstalls.
- Error path (misalign/illegal): 2 cycles, `stall_pipl` high 1 cycle.
- Reset mid-BUS: cyc/stb drop asynchronously, no completion, no `bus_err`.
- Ack/err outside BUS ignored.

## Configuration
- `DBUS_TIMEOUT_EN` defined: 16-bit counter clears on BUS entry, increments each BUS cycle; reaching `TIMEOUT_CYCLES` without ack/err → drop cyc/stb, error flag, → DONE (`mem_rdata_mem`=0, `bus_err` pulse). Ack on the same cycle as expiry wins.
- Undefined: no counter; BUS waits indefinitely.

## Structure
- Package `dbus_pkg`: state enum (IDLE/BUS/DONE), funct3 localparams `MEM_OP_B/H/W/BU/HU`.
- Sub-module `dbus_lane_align`: combinational sel/wdata generation, misalign/illegal detection and load extraction; bridge holds FSM, registers, timeout counter.

## Test plan
- LW addr 0x1000, slave returns 0xDEADBEEF with ack after 1 wait → sel 4'hF, adr 0x1000, stall 3 cycles, rdata 0xDEADBEEF.
- LB addr 0x1003, data 0x80112233 → sel 4'b1000, rdata 0xFFFFFF80; LBU same → 0x00000080.
- SH addr 0x2002, wdata 0x0000ABCD → we=1, sel 4'b1100, dat 0xABCDABCD, rdata unchanged.
- LW addr 0x1002 → no wb_cyc_o, stall 1 cycle, bus_err pulse, rdata 0.
- Slave asserts wb_err_i on SW → bus_err pulse in DONE; reset asserted mid-BUS → cyc/stb 0 immediately, state IDLE.
- `DBUS_TIMEOUT_EN`, TIMEOUT_CYCLES=4, no ack → abort after 4 BUS cycles, bus_err pulse, rdata 0.
